tc: RTL and testbench

Memory-mapped timer/counter peripheral that answers the processor's load/store traffic. It is the responder end of the data-memory interface: the CPU core drives word address, write enable and write data exactly as it does for data memory, and reads back register contents. It also generates the interrupt request that feeds the coprocessor-0 interrupt input. Three word registers are provided: CTRL, PRESET and COUNT. A four-state FSM loads, counts down and signals expiry, either once or periodically.

---
 rtl/tc.sv | 114 +++++++++++
 tb/tb_tc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tc.sv
// tc: memory-mapped timer/counter with CTRL, PRESET and COUNT registers.
// Ports: clk, reset (sync, active-high), addr/we/wd bus in, rd/irq out.
module tc #(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic        wr_ctrl;
  logic        wr_pre;
  logic        en_eff;

  assign wr_ctrl = we && (addr == 2'd0);
  assign wr_pre  = we && (addr == 2'd1);

  // A CTRL write takes effect on the FSM at the same edge it lands.
  assign en_eff = wr_ctrl ? wd[0] : ctrl_q[0];

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    if (wr_ctrl) ctrl_d = wd[3:0];
    if (wr_pre) preset_d = wd;
    if (wr_ctrl || wr_pre) flag_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en_eff) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!en_eff) begin
          state_d = S_IDLE;
        end else begin
          count_d = preset_q;
          state_d = S_CNT;
        end
      end
      S_CNT: begin
        if (!en_eff) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (ctrl_q[2:1] == 2'b01) begin
          flag_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          // One-shot: a concurrent CPU CTRL write beats the EN clear.
          if (!wr_ctrl) ctrl_d[0] = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= RESET_PRESET;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rd = '0;
    unique case (addr)
      2'd0:    rd = {28'd0, ctrl_q};
      2'd1:    rd = preset_q;
      2'd2:    rd = count_q;
      default: rd = '0;
    endcase
  end

  assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_tc.sv
// tb_tc: directed vector table plus hand-written sequences for tc.
// Drives bus at posedge+1, samples rd/irq at negedge.
module tb_tc;

  localparam logic [31:0] RP = 32'hCAFE_0007;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int checks = 0;
  int errors = 0;

  tc #(.RESET_PRESET(RP)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  a;
    logic        w;
    logic [31:0] d;
    logic [31:0] erd;
    logic        eirq;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [1:0] a, input logic w,
                              input logic [31:0] d, input logic [31:0] erd,
                              input logic eirq);
    vec_t v;
    v.a = a; v.w = w; v.d = d; v.erd = erd; v.eirq = eirq;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill();
    // reset values
    add(0, 0, 0, 0, 0);
    add(1, 0, 0, RP, 0);
    add(2, 0, 0, 0, 0);
    add(3, 0, 0, 0, 0);
    // writes to unused and COUNT are ignored
    add(3, 1, 32'hFFFF_FFFF, 0, 0);
    add(3, 0, 0, 0, 0);
    add(2, 1, 32'd123, 0, 0);
    add(2, 0, 0, 0, 0);
    // one-shot, P=5, IM=1
    add(1, 1, 32'd5, RP, 0);
    add(0, 1, 32'h9, 0, 0);
    add(2, 0, 0, 0, 0);
    for (int i = 5; i >= 1; i--) add(2, 0, 0, i, 0);
    add(2, 0, 0, 0, 1);
    add(0, 0, 0, 32'h8, 1);
    add(0, 0, 0, 32'h8, 1);
    add(0, 1, 32'hFFFF_FFF0, 32'h8, 1);
    add(0, 0, 0, 0, 0);
    // auto-reload, P=3
    add(1, 1, 32'd3, 32'd5, 0);
    add(0, 1, 32'hB, 0, 0);
    add(2, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 3; i >= 1; i--) add(2, 0, 0, i, 0);
      add(2, 0, 0, 0, 1);
      add(2, 0, 0, 0, 0);
    end
    add(2, 0, 0, 3, 0);
    add(0, 0, 0, 32'hB, 0);
    add(0, 1, 0, 32'hB, 0);
    add(2, 0, 0, 1, 0);
    add(2, 0, 0, 1, 0);
    // pause / resume, P=10, IM=0 one-shot
    add(1, 1, 32'd10, 32'd3, 0);
    add(0, 1, 32'h1, 0, 0);
    add(2, 0, 0, 1, 0);
    for (int i = 10; i >= 7; i--) add(2, 0, 0, i, 0);
    add(0, 1, 0, 32'h1, 0);
    add(2, 0, 0, 6, 0);
    add(2, 0, 0, 6, 0);
    add(0, 1, 32'h1, 0, 0);
    add(2, 0, 0, 6, 0);
    for (int i = 10; i >= 1; i--) add(2, 0, 0, i, 0);
    add(2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(0, 1, 32'h8, 0, 0);
    add(0, 0, 0, 32'h8, 0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit got;
    reset = 1'b1; we = 1'b0; addr = '0; wd = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    fill();

    foreach (vq[i]) begin
      addr = vq[i].a; we = vq[i].w; wd = vq[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d_rd", i), rd, vq[i].erd);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vq[i].eirq});
      next_cyc();
    end
    we = 1'b0;

    // reset mid-count in auto-reload, concurrent PRESET write
    addr = 1; we = 1; wd = 32'd6;
    next_cyc();
    addr = 0; wd = 32'hB;
    next_cyc();
    we = 0; addr = 2;
    repeat (3) next_cyc();
    @(negedge clk);
    chk("rst_pre_count", rd, 32'd4);
    reset = 1; we = 1; addr = 1; wd = 32'h77;
    @(posedge clk);
    #1 reset = 0; we = 0;
    addr = 0; #1 chk("rst_ctrl", rd, 0);
    addr = 1; #1 chk("rst_preset", rd, RP);
    addr = 2; #1 chk("rst_count", rd, 0);
    addr = 3; #1 chk("rst_unused", rd, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    repeat (3) next_cyc();
    chk("rst_idle_count", rd, 0);

    // P=0 one-shot: INT three cycles after enable
    addr = 1; we = 1; wd = 32'd0;
    next_cyc();
    addr = 0; wd = 32'h9;
    next_cyc();
    we = 0; addr = 2;
    n = 1; got = 0;
    while (n <= 20 && !got) begin
      @(negedge clk);
      if (irq) got = 1;
      else begin
        next_cyc();
        n++;
      end
    end
    chk("p0_int_cycle", got ? n : 0, 3);
    if (got) begin
      // CPU write in the INT cycle beats the EN clear
      we = 1; addr = 0; wd = 32'hD;
      next_cyc();
      we = 0;
      @(negedge clk);
      chk("int_wr_ctrl", rd, 32'hD);
      chk("int_wr_irq", {31'd0, irq}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
